id_ex_stage_reg: RTL and testbench

//   ID/EX pipeline register with load-use hazard detection, directly downstream of the decode control unit.

---
 rtl/id_ex_stage_reg_if.sv | 74 +++++++
 rtl/id_ex_stage_reg.sv | 130 +++++++++++++
 tb/tb_id_ex_stage_reg.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decode-side fields, flush/hold controls,
// upstream stall request and the registered EX-side fields.
interface id_ex_stage_reg_if #(
    parameter int XLEN = 64,
    parameter int RIDX = 5
);
    logic            id_valid;
    logic            id_branch;
    logic            id_mem_read;
    logic            id_mem_to_reg;
    logic            id_mem_write;
    logic            id_alu_src;
    logic            id_reg_write;
    logic [1:0]      id_alu_op;
    logic [3:0]      id_funct;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [RIDX-1:0] id_rs1;
    logic [RIDX-1:0] id_rs2;
    logic [RIDX-1:0] id_rd;

    logic            flush;
    logic            hold;
    logic            stall;

    logic            ex_valid;
    logic            ex_branch;
    logic            ex_mem_read;
    logic            ex_mem_to_reg;
    logic            ex_mem_write;
    logic            ex_alu_src;
    logic            ex_reg_write;
    logic [1:0]      ex_alu_op;
    logic [3:0]      ex_funct;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RIDX-1:0] ex_rs1;
    logic [RIDX-1:0] ex_rs2;
    logic [RIDX-1:0] ex_rd;

    modport master (
        output id_valid, id_branch, id_mem_read, id_mem_to_reg,
        output id_mem_write, id_alu_src, id_reg_write,
        output id_alu_op, id_funct,
        output id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd,
        output flush, hold,
        input  stall,
        input  ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg,
        input  ex_mem_write, ex_alu_src, ex_reg_write,
        input  ex_alu_op, ex_funct,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd
    );

    modport slave (
        input  id_valid, id_branch, id_mem_read, id_mem_to_reg,
        input  id_mem_write, id_alu_src, id_reg_write,
        input  id_alu_op, id_funct,
        input  id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd,
        input  flush, hold,
        output stall,
        output ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg,
        output ex_mem_write, ex_alu_src, ex_reg_write,
        output ex_alu_op, ex_funct,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Define PERF_CNT_EN to add saturating stall/flush event counters.
module id_ex_stage_reg #(
    parameter int XLEN = 64,
    parameter int RIDX = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_stage_reg_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic            branch;
        logic            mem_read;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic [1:0]      alu_op;
        logic [3:0]      funct;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
    } id_ex_t;

    id_ex_t id_in;
    id_ex_t ex_q;
    id_ex_t ex_d;

    logic ex_load;
    logic uses_rs2;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    always_comb begin
        id_in            = '0;
        id_in.valid      = bus.id_valid;
        id_in.branch     = bus.id_branch;
        id_in.mem_read   = bus.id_mem_read;
        id_in.mem_to_reg = bus.id_mem_to_reg;
        id_in.mem_write  = bus.id_mem_write;
        id_in.alu_src    = bus.id_alu_src;
        id_in.reg_write  = bus.id_reg_write;
        id_in.alu_op     = bus.id_alu_op;
        id_in.funct      = bus.id_funct;
        id_in.pc         = bus.id_pc;
        id_in.rs1_data   = bus.id_rs1_data;
        id_in.rs2_data   = bus.id_rs2_data;
        id_in.imm        = bus.id_imm;
        id_in.rs1        = bus.id_rs1;
        id_in.rs2        = bus.id_rs2;
        id_in.rd         = bus.id_rd;
    end

    // reg_write keeps the decoder's unknown-opcode default out of hazards
    assign ex_load  = ex_q.valid & ex_q.mem_read & ex_q.reg_write;
    assign uses_rs2 = ~bus.id_alu_src | bus.id_mem_write;
    assign rs1_hit  = (ex_q.rd == bus.id_rs1);
    assign rs2_hit  = uses_rs2 & (ex_q.rd == bus.id_rs2);

    assign hazard = bus.id_valid & ex_load & (|ex_q.rd)
                  & (rs1_hit | rs2_hit);

    assign bus.stall = rst_n & ~bus.flush & (bus.hold | hazard);

    always_comb begin
        ex_d = ex_q;
        priority case (1'b1)
            bus.flush: ex_d = '0;
            bus.hold:  ex_d = ex_q;
            hazard:    ex_d = '0;
            default:   ex_d = bus.id_valid ? id_in : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_funct      = ex_q.funct;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rs1_data   = ex_q.rs1_data;
    assign bus.ex_rs2_data   = ex_q.rs2_data;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_rd         = ex_q.rd;

`ifdef PERF_CNT_EN
    logic stall_evt;

    assign stall_evt = hazard & ~bus.flush & ~bus.hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_evt && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (bus.flush && !(&perf_flush_cnt))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized bench for id_ex_stage_reg against a behavioural model.
// Directed load-use, flush and hold cases followed by random traffic.
module tb_id_ex_stage_reg;
    localparam int XLEN = 64;
    localparam int RIDX = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.XLEN(XLEN), .RIDX(RIDX)) bus ();

`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    id_ex_stage_reg #(.XLEN(XLEN), .RIDX(RIDX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic [1:0]  alu_op;
        logic [3:0]  funct;
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } instr_t;

    instr_t cur;
    instr_t m_ex;
    int     checks;
    int     errors;
    logic   last_stall;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic instr_t ones();
        instr_t b;
        b = '{default: '1};
        return b;
    endfunction

    function automatic instr_t mk(logic mr, logic rw, logic asrc,
                                  logic mw, logic [4:0] r1,
                                  logic [4:0] r2, logic [4:0] d,
                                  logic [63:0] pc);
        instr_t b;
        b = bubble();
        b.valid = 1'b1;
        b.mem_read = mr;
        b.mem_to_reg = mr;
        b.reg_write = rw;
        b.alu_src = asrc;
        b.mem_write = mw;
        b.alu_op = 2'b10;
        b.funct = 4'h3;
        b.pc = pc;
        b.rs1_data = pc ^ 64'h1111_2222_3333_4444;
        b.rs2_data = pc + 64'd77;
        b.imm = ~pc;
        b.rs1 = r1;
        b.rs2 = r2;
        b.rd = d;
        return b;
    endfunction

    function automatic instr_t rnd();
        instr_t b;
        b.valid = ($urandom_range(0, 7) != 0);
        b.branch = 1'($urandom);
        b.mem_read = 1'($urandom);
        b.mem_to_reg = 1'($urandom);
        b.mem_write = 1'($urandom);
        b.alu_src = 1'($urandom);
        b.reg_write = ($urandom_range(0, 3) != 0);
        b.alu_op = 2'($urandom);
        b.funct = 4'($urandom);
        b.pc = {$urandom, $urandom};
        b.rs1_data = {$urandom, $urandom};
        b.rs2_data = {$urandom, $urandom};
        b.imm = {$urandom, $urandom};
        b.rs1 = 5'($urandom_range(0, 3));
        b.rs2 = 5'($urandom_range(0, 3));
        b.rd = 5'($urandom_range(0, 3));
        return b;
    endfunction

    task automatic drive(instr_t i);
        cur = i;
        bus.id_valid      = i.valid;
        bus.id_branch     = i.branch;
        bus.id_mem_read   = i.mem_read;
        bus.id_mem_to_reg = i.mem_to_reg;
        bus.id_mem_write  = i.mem_write;
        bus.id_alu_src    = i.alu_src;
        bus.id_reg_write  = i.reg_write;
        bus.id_alu_op     = i.alu_op;
        bus.id_funct      = i.funct;
        bus.id_pc         = i.pc;
        bus.id_rs1_data   = i.rs1_data;
        bus.id_rs2_data   = i.rs2_data;
        bus.id_imm        = i.imm;
        bus.id_rs1        = i.rs1;
        bus.id_rs2        = i.rs2;
        bus.id_rd         = i.rd;
    endtask

    // True when a load now in EX writes a register the ID instruction reads
    function automatic logic load_use(instr_t ex, instr_t id);
        logic is_load;
        logic reads_rs2;
        is_load = ex.valid && ex.mem_read && ex.reg_write;
        reads_rs2 = !id.alu_src || id.mem_write;
        if (!id.valid || !is_load || ex.rd == 5'd0) return 1'b0;
        if (ex.rd == id.rs1) return 1'b1;
        return reads_rs2 && ex.rd == id.rs2;
    endfunction

    task automatic check_ex();
        chk("ctrl",
            {bus.ex_valid, bus.ex_branch, bus.ex_mem_read,
             bus.ex_mem_to_reg, bus.ex_mem_write, bus.ex_alu_src,
             bus.ex_reg_write, bus.ex_alu_op, bus.ex_funct},
            {m_ex.valid, m_ex.branch, m_ex.mem_read,
             m_ex.mem_to_reg, m_ex.mem_write, m_ex.alu_src,
             m_ex.reg_write, m_ex.alu_op, m_ex.funct});
        chk("pc", bus.ex_pc, m_ex.pc);
        chk("rs1_data", bus.ex_rs1_data, m_ex.rs1_data);
        chk("rs2_data", bus.ex_rs2_data, m_ex.rs2_data);
        chk("imm", bus.ex_imm, m_ex.imm);
        chk("idx", {bus.ex_rs1, bus.ex_rs2, bus.ex_rd},
            {m_ex.rs1, m_ex.rs2, m_ex.rd});
`ifdef PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stall_cnt);
        chk("perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
    endtask

    // One cycle: check stall before the edge, advance model, check EX
    task automatic step();
        logic hz;
        logic exp_stall;
        hz = load_use(m_ex, cur);
        exp_stall = rst_n && !bus.flush && (bus.hold || hz);
        #1;
        chk("stall", bus.stall, exp_stall);
        last_stall = exp_stall;
        @(posedge clk);
        if (!rst_n) begin
            m_ex = bubble();
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (bus.flush && m_flush_cnt != 32'hFFFF_FFFF)
                m_flush_cnt++;
            if (hz && !bus.flush && !bus.hold &&
                m_stall_cnt != 32'hFFFF_FFFF)
                m_stall_cnt++;
            if (bus.flush) m_ex = bubble();
            else if (bus.hold) m_ex = m_ex;
            else if (hz) m_ex = bubble();
            else if (cur.valid) m_ex = cur;
            else m_ex = bubble();
        end
        @(negedge clk);
        check_ex();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.hold = 1'b0;
        drive(bubble());
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ex = bubble();
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        last_stall = 1'b0;

        // all-ones inputs under reset
        rst_n = 1'b0;
        bus.flush = 1'b1;
        bus.hold = 1'b1;
        drive(ones());
        step();
        step();
        chk("rst_valid", bus.ex_valid, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        do_reset();

        // load-use: one bubble, then the dependent add enters EX
        drive(mk(1, 1, 1, 0, 5'd1, 5'd2, 5'd5, 64'h40));
        step();
        drive(mk(0, 1, 0, 0, 5'd5, 5'd7, 5'd6, 64'h44));
        step();
        chk("lu_stall", last_stall, 1'b1);
        chk("lu_bubble", bus.ex_valid, 1'b0);
        step();
        chk("lu_release", bus.stall, 1'b0);
        chk("lu_add_pc", bus.ex_pc, 64'h44);

        // load to x0 never stalls
        drive(mk(1, 1, 1, 0, 5'd1, 5'd2, 5'd0, 64'h80));
        step();
        drive(mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd3, 64'h84));
        step();
        chk("x0_stall", last_stall, 1'b0);
        chk("x0_valid", bus.ex_valid, 1'b1);

        // mem_read without reg_write is not a load
        drive(mk(1, 0, 1, 0, 5'd1, 5'd2, 5'd5, 64'hC0));
        step();
        drive(mk(0, 1, 0, 0, 5'd5, 5'd5, 5'd3, 64'hC4));
        step();
        chk("norw_stall", last_stall, 1'b0);

        // hazard together with flush
        do_reset();
        drive(mk(1, 1, 1, 0, 5'd1, 5'd2, 5'd5, 64'hE0));
        step();
        drive(mk(0, 1, 0, 0, 5'd5, 5'd7, 5'd6, 64'hE4));
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl_stall", last_stall, 1'b0);
        chk("fl_bubble", bus.ex_valid, 1'b0);

        // hold keeps EX frozen for three cycles
        drive(mk(0, 1, 1, 0, 5'd1, 5'd2, 5'd9, 64'h100));
        step();
        drive(mk(0, 1, 1, 0, 5'd3, 5'd4, 5'd10, 64'h104));
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stall", last_stall, 1'b1);
            chk("hold_rd", bus.ex_rd, 64'd9);
            chk("hold_pc", bus.ex_pc, 64'h100);
        end
        bus.hold = 1'b0;
        step();
        chk("unhold_pc", bus.ex_pc, 64'h104);

        // random traffic; stalled instructions are re-presented
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!last_stall || bus.flush) drive(rnd());
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.hold = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
